uart_rx_engine: RTL and testbench

- Serial receive end of the UART link. The transmit shift register serialises the frame idle-mark, start(0), 7 or 8 data bits LSB first, optional parity, stop(1).
- This block detects the start bit, times each bit from a programmable bit period and samples at mid-bit. It reassembles the character, checks parity and stop, and presents the byte with ready/error flags to the register interface.

---
 rtl/uart_rx_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit detect, mid-bit sampling, parity/stop check, ready/overrun flags.
// Optional build macro RX_MAJORITY_VOTE_EN: 2-of-3 vote around each bit center (+1 clk latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs = 0
// S_START | timing half a bit, then re-checking the start bit
// S_DATA  | sampling data and parity bits, one per bit period
// S_STOP  | timing one bit period, then sampling the stop bit
// S_DONE  | one cycle: publish character and error/ready flags

module uart_rx_engine #(
   parameter int CNT_W  = 19,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_in,
   input  logic [CNT_W-1:0] baud_k,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   input  logic             clr_rdy,
   output logic [7:0]       rx_data,
   output logic             rxrdy,
   output logic             perr,
   output logic             ferr,
   output logic             ovf,
   output logic             busy
);

   localparam int SH_W = DATA_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             rxs_q, rxs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [CNT_W-1:0] half_ld;
   logic [3:0]       bit_left_q, bit_left_d;
   logic [3:0]       n_bits;
   logic [SH_W-1:0]  sh_q, sh_d;
   logic [SH_W-1:0]  sh_just;
   logic             eight_q, eight_d;
   logic             pen_q, pen_d;
   logic             ohel_q, ohel_d;
   logic             stop_q, stop_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [7:0]       data_just;
   logic             rxrdy_q, rxrdy_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             ovf_q, ovf_d;
   logic             tc;
   logic             bit_val;
   logic             par_bit;
   logic             perr_calc;
   logic             ld_start;
   logic             smp_start;
   logic             smp_data;
   logic             smp_stop;
   logic             in_done;

   always_comb begin
      sync1_d = rx_in;
      rxs_d   = sync1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         rxs_q   <= rxs_d;
      end
   end

`ifdef RX_MAJORITY_VOTE_EN
   // hist_q[0] = rxs one clk ago, hist_q[1] = two clks ago; the decision lands at center+1
   logic [1:0] hist_q, hist_d;

   always_comb hist_d = {hist_q[0], rxs_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hist_q <= 2'b11;
      else        hist_q <= hist_d;
   end

   assign bit_val = (rxs_q & hist_q[0]) | (rxs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
   assign half_ld = baud_k >> 1;
`else
   assign bit_val = rxs_q;
   assign half_ld = (baud_k >> 1) - CNT_W'(1);
`endif

   assign tc = (cnt_q == '0);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rxs_q) state_d = S_START;
         S_START: if (tc) state_d = bit_val ? S_IDLE : S_DATA;
         S_DATA:  if (tc && (bit_left_q == 4'd1)) state_d = S_STOP;
         S_STOP:  if (tc) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = 1'b1;
      ld_start  = 1'b0;
      smp_start = 1'b0;
      smp_data  = 1'b0;
      smp_stop  = 1'b0;
      in_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            ld_start = ~rxs_q;
         end
         S_START: smp_start = tc;
         S_DATA:  smp_data  = tc;
         S_STOP:  smp_stop  = tc;
         S_DONE:  in_done   = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   // Bits land MSB-first in a right shifter; shift right so the first data bit sits at bit 0.
   assign n_bits    = 4'd7 + {3'b000, eight_q} + {3'b000, pen_q};
   assign sh_just   = sh_q >> (4'(SH_W) - n_bits);
   assign data_just = eight_q ? sh_just[7:0] : {1'b0, sh_just[6:0]};
   assign par_bit   = eight_q ? sh_just[8] : sh_just[7];
   assign perr_calc = pen_q & (^data_just ^ par_bit ^ ohel_q);

   always_comb begin
      cnt_d      = cnt_q;
      baud_d     = baud_q;
      eight_d    = eight_q;
      pen_d      = pen_q;
      ohel_d     = ohel_q;
      bit_left_d = bit_left_q;
      sh_d       = sh_q;
      stop_d     = stop_q;
      if (ld_start) begin
         cnt_d   = half_ld;
         baud_d  = baud_k;
         eight_d = eight;
         pen_d   = pen;
         ohel_d  = ohel;
         sh_d    = '1;
      end else if (busy && !in_done) begin
         cnt_d = tc ? (baud_q - CNT_W'(1)) : (cnt_q - CNT_W'(1));
      end
      if (smp_start) bit_left_d = n_bits;
      if (smp_data) begin
         sh_d       = {bit_val, sh_q[SH_W-1:1]};
         bit_left_d = bit_left_q - 4'd1;
      end
      if (smp_stop) stop_d = bit_val;
   end

   // A read strobe coinciding with DONE retires the previous character, so no overrun.
   always_comb begin
      rx_data_d = rx_data_q;
      rxrdy_d   = rxrdy_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovf_d     = ovf_q;
      if (clr_rdy) begin
         rxrdy_d = 1'b0;
         ovf_d   = 1'b0;
      end
      if (in_done) begin
         rx_data_d = data_just;
         perr_d    = perr_calc;
         ferr_d    = ~stop_q;
         rxrdy_d   = 1'b1;
         if (rxrdy_q && !clr_rdy) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         baud_q     <= '0;
         eight_q    <= 1'b0;
         pen_q      <= 1'b0;
         ohel_q     <= 1'b0;
         bit_left_q <= '0;
         sh_q       <= '1;
         stop_q     <= 1'b0;
         rx_data_q  <= '0;
         rxrdy_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         baud_q     <= baud_d;
         eight_q    <= eight_d;
         pen_q      <= pen_d;
         ohel_q     <= ohel_d;
         bit_left_q <= bit_left_d;
         sh_q       <= sh_d;
         stop_q     <= stop_d;
         rx_data_q  <= rx_data_d;
         rxrdy_q    <= rxrdy_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rxrdy   = rxrdy_q;
   assign perr    = perr_q;
   assign ferr    = ferr_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: frames are serialised on rx_in, the expected result is
// queued, and a monitor compares when busy falls (end of a frame or a rejected false start).

module tb_uart_rx_engine;

   localparam int CNT_W = 19;
`ifdef RX_MAJORITY_VOTE_EN
   localparam int VOTE = 1;
`else
   localparam int VOTE = 0;
`endif

   logic             clk     = 1'b0;
   logic             reset   = 1'b0;
   logic             rx_in   = 1'b1;
   logic [CNT_W-1:0] baud_k  = 19'd16;
   logic             eight   = 1'b1;
   logic             pen     = 1'b0;
   logic             ohel    = 1'b0;
   logic             clr_rdy = 1'b0;
   logic [7:0]       rx_data;
   logic             rxrdy, perr, ferr, ovf, busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] data;
      logic       rdy;
      logic       perr;
      logic       ferr;
      logic       ovf;
      int         lat_min;
      int         t0;
   } exp_t;

   exp_t sb_q[$];

   // reference state of the register interface
   logic [7:0] m_data = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovf  = 1'b0;

   uart_rx_engine #(.CNT_W(CNT_W), .DATA_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .rx_in   (rx_in),
      .baud_k  (baud_k),
      .eight   (eight),
      .pen     (pen),
      .ohel    (ohel),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rxrdy   (rxrdy),
      .perr    (perr),
      .ferr    (ferr),
      .ovf     (ovf),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic busy_prev = 1'b0;
   exp_t mon_e;
   int   mon_lat;

   always @(negedge clk) begin
      if (!reset) begin
         busy_prev = 1'b0;
      end else begin
         if (busy_prev && !busy) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event: got busy fall at cycle %0d expected none", cyc);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
               chk("rxrdy", {31'd0, rxrdy}, {31'd0, mon_e.rdy});
               chk("perr", {31'd0, perr}, {31'd0, mon_e.perr});
               chk("ferr", {31'd0, ferr}, {31'd0, mon_e.ferr});
               chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
               mon_lat = cyc - mon_e.t0;
               checks++;
               if (mon_lat < mon_e.lat_min || mon_lat > mon_e.lat_min + 2) begin
                  failures++;
                  $display("FAIL latency: got %0d clk expected %0d..%0d clk",
                           mon_lat, mon_e.lat_min, mon_e.lat_min + 2);
               end
            end
         end
         busy_prev = busy;
      end
   end

   // ---------------- stimulus ----------------
   // Serialise one frame. abort_bit >= 0 asserts reset mid-way through that data bit.
   task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe, input logic oh,
                             input int b, input logic bad_par, input logic bad_stop,
                             input logic clr_done, input int abort_bit);
      int         nb, n, half, ones, dedge, c0;
      logic [7:0] dm;
      logic       pbit, ep;
      logic       bits [0:11];
      exp_t       e;
      nb   = 7 + int'(e8);
      n    = nb + int'(pe);
      half = b / 2;
      dm   = e8 ? d : {1'b0, d[6:0]};
      ones = $countones(dm);
      pbit = ((ones % 2) == 1) ^ oh ^ bad_par;
      bits[0] = 1'b0;
      for (int i = 0; i < nb; i++) bits[1 + i] = dm[i];
      if (pe) bits[1 + nb] = pbit;
      bits[n + 1] = 1'b1;

      @(posedge clk); #1;
      baud_k = CNT_W'(b);
      eight  = e8;
      pen    = pe;
      ohel   = oh;
      @(posedge clk); #1;
      c0    = cyc;
      // the DONE cycle begins this many edges after rx_in falls (2-flop sync + half bit + N+1 bits + 1)
      dedge = c0 + (n + 1) * b + 3 + half + VOTE;

      if (abort_bit < 0) begin
         if (pe) ones = ones + int'(pbit);
         ep = pe && ((oh && (ones % 2 == 0)) || (!oh && (ones % 2 == 1)));
         e.data    = dm;
         e.rdy     = 1'b1;
         e.perr    = ep;
         e.ferr    = bad_stop;
         e.ovf     = clr_done ? 1'b0 : (m_rdy ? 1'b1 : m_ovf);
         e.lat_min = 3 + half + (n + 1) * b;
         e.t0      = c0;
         m_data = e.data; m_rdy = e.rdy; m_perr = e.perr; m_ferr = e.ferr; m_ovf = e.ovf;
         sb_q.push_back(e);
      end

      for (int i = 0; i <= n + 1; i++) begin
         rx_in = bits[i];
         if (i == n + 1 && bad_stop) rx_in = 1'b0;
         for (int k = 1; k <= b; k++) begin
            @(posedge clk); #1;
            clr_rdy = clr_done && (cyc == dedge);
            // a bad stop must end well before the next IDLE check, else it reads as a break
            if (i == n + 1 && bad_stop && k == half + 2) rx_in = 1'b1;
            if (abort_bit >= 0 && i == abort_bit + 1 && k == half) begin
               reset = 1'b0;
               #1;
               chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
               chk("rst_rxrdy", {31'd0, rxrdy}, 32'd0);
               chk("rst_perr", {31'd0, perr}, 32'd0);
               chk("rst_ferr", {31'd0, ferr}, 32'd0);
               chk("rst_ovf", {31'd0, ovf}, 32'd0);
               chk("rst_busy", {31'd0, busy}, 32'd0);
               rx_in   = 1'b1;
               clr_rdy = 1'b0;
               m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
               return;
            end
         end
      end
      rx_in   = 1'b1;
      clr_rdy = 1'b0;
   endtask

   task automatic send_glitch();
      exp_t e;
      @(posedge clk); #1;
      baud_k = 19'd16;
      @(posedge clk); #1;
      e.data = m_data; e.rdy = m_rdy; e.perr = m_perr; e.ferr = m_ferr; e.ovf = m_ovf;
      e.lat_min = 2 + 8;
      e.t0      = cyc;
      sb_q.push_back(e);
      rx_in = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (20) @(posedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (3 + $urandom_range(0, 6)) @(posedge clk);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_rdy = 1'b1;
      @(posedge clk); #1 clr_rdy = 1'b0;
      m_rdy = 1'b0;
      m_ovf = 1'b0;
      chk("clr_rxrdy", {31'd0, rxrdy}, {31'd0, m_rdy});
      chk("clr_ovf", {31'd0, ovf}, {31'd0, m_ovf});
      chk("clr_perr_hold", {31'd0, perr}, {31'd0, m_perr});
      chk("clr_ferr_hold", {31'd0, ferr}, {31'd0, m_ferr});
      chk("clr_data_hold", {24'd0, rx_data}, {24'd0, m_data});
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_rx_data", {24'd0, rx_data}, 32'd0);
      chk("init_rxrdy", {31'd0, rxrdy}, 32'd0);
      chk("init_perr", {31'd0, perr}, 32'd0);
      chk("init_ferr", {31'd0, ferr}, 32'd0);
      chk("init_ovf", {31'd0, ovf}, 32'd0);
      chk("init_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      repeat (4) @(posedge clk);

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      pulse_clr();
      send_frame(8'h41, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      send_frame(8'h41, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0, -1); wait_idle();
      pulse_clr();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, -1); wait_idle();
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      pulse_clr();
      send_glitch(); wait_idle();
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      pulse_clr();
      send_frame(8'h44, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();
      send_frame(8'h66, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1, -1); wait_idle();
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 3);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1); wait_idle();

      for (int r = 0; r < 30; r++) begin
         logic [7:0] d;
         logic       e8, pe, oh, bp, bs, cd;
         int         b;
         d  = 8'($urandom);
         e8 = 1'($urandom_range(0, 1));
         pe = 1'($urandom_range(0, 1));
         oh = 1'($urandom_range(0, 1));
         b  = int'($urandom_range(16, 40));
         bp = pe && ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 4) == 0);
         cd = ($urandom_range(0, 4) == 0);
         send_frame(d, e8, pe, oh, b, bp, bs, cd, -1);
         wait_idle();
         if ($urandom_range(0, 1) == 1) pulse_clr();
         if ($urandom_range(0, 7) == 0) begin
            send_glitch();
            wait_idle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish before 100000 clk");
      $fatal(1, "watchdog expired");
   end

endmodule
